// File: rtl/ball_pkg.sv
// Shared types and constants for the ball motion engine.
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    LOST = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/ball_axis_step.sv
// One axis of ball motion: position +/- velocity, clamped to [0, HI],
// with a bounce flag whenever a clamp was applied.
module ball_axis_step #(
  parameter int W  = 10,
  parameter int HI = 624
) (
  input  logic [W-1:0] pos,
  input  logic [W-1:0] vel,
  input  logic         inc,
  output logic [W-1:0] next_pos,
  output logic         bounce
);

  // One extra bit so pos + vel cannot wrap before the clamp compare.
  logic [W:0] sum;

  always_comb begin
    sum      = {1'b0, pos} + {1'b0, vel};
    next_pos = W'(sum);
    bounce   = 1'b0;
    if (inc) begin
      if (sum >= (W+1)'(HI)) begin
        next_pos = W'(HI);
        bounce   = 1'b1;
      end
    end else if (pos < vel) begin
      next_pos = '0;
      bounce   = 1'b1;
    end else begin
      next_pos = pos - vel;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Brick-breaker ball engine: serve, per-frame motion, wall/paddle/brick
// reflections, speed-up on paddle hits, and lives bookkeeping.
module ball_engine
  import ball_pkg::*;
#(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 16,
  parameter int PADDLE_W       = 80,
  parameter int PADDLE_Y       = 448,
  parameter int POS_W          = 10,
  parameter int VEL_INIT       = 4,
  parameter int VEL_MAX        = 8,
  parameter int HITS_PER_LEVEL = 4,
  parameter int LIVES          = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             game_run,
  input  logic             launch,
  input  logic [POS_W-1:0] paddle_x,
  input  logic             brick_hit,
  input  logic             brick_axis,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic [3:0]       speed,
  output logic [1:0]       lives_left,
  output logic             ball_lost,
  output logic             game_over,
  output logic             display_ball
);

  localparam int AW     = POS_W + 1;
  localparam int XMAX   = SCREEN_W - BALL_SIZE;
  localparam int YMAX   = SCREEN_H - BALL_SIZE;
  localparam int PARK_Y = PADDLE_Y - BALL_SIZE;

  state_t           state;
  logic             pend_x, pend_y;
  logic [3:0]       hit_cnt;
  logic             move_tick, eff_dx, eff_dy;
  logic             bx, by, paddle_hit, floor_hit;
  logic [POS_W-1:0] vel, nx, ny, park_x;
  logic [AW-1:0]    x_w, y_w, v_w, px_w, center;

  assign move_tick = frame_tick && game_run && (state == MOVE);
  // Pending brick flags toggle direction before this tick's step.
  assign eff_dx    = dir_x ^ pend_x;
  assign eff_dy    = dir_y ^ pend_y;
  assign vel       = POS_W'(speed);
  assign x_w       = {1'b0, ball_x};
  assign y_w       = {1'b0, ball_y};
  assign v_w       = {1'b0, vel};
  assign px_w      = {1'b0, paddle_x};

  ball_axis_step #(.W(POS_W), .HI(XMAX)) u_step_x (
    .pos(ball_x), .vel(vel), .inc(eff_dx), .next_pos(nx), .bounce(bx)
  );

  ball_axis_step #(.W(POS_W), .HI(YMAX)) u_step_y (
    .pos(ball_y), .vel(vel), .inc(eff_dy), .next_pos(ny), .bounce(by)
  );

  assign paddle_hit = (eff_dy == DIR_DOWN)
                   && (y_w + AW'(BALL_SIZE) <= AW'(PADDLE_Y))
                   && (y_w + v_w + AW'(BALL_SIZE) >= AW'(PADDLE_Y))
                   && (x_w + AW'(BALL_SIZE) > px_w)
                   && (x_w < px_w + AW'(PADDLE_W));
  assign floor_hit  = (eff_dy == DIR_DOWN) && (y_w + v_w >= AW'(YMAX));

  // Parked ball sits centred on the paddle, kept inside the playfield.
  always_comb begin
    center = px_w + AW'(PADDLE_W / 2);
    if (center < AW'(BALL_SIZE / 2))
      park_x = '0;
    else if (center - AW'(BALL_SIZE / 2) > AW'(XMAX))
      park_x = POS_W'(XMAX);
    else
      park_x = POS_W'(center - AW'(BALL_SIZE / 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ball_x       <= POS_W'((SCREEN_W - BALL_SIZE) / 2);
      ball_y       <= POS_W'(PARK_Y);
      dir_x        <= DIR_RIGHT;
      dir_y        <= ~DIR_DOWN;
      speed        <= 4'(VEL_INIT);
      hit_cnt      <= '0;
      lives_left   <= 2'(LIVES);
      ball_lost    <= 1'b0;
      game_over    <= 1'b0;
      display_ball <= 1'b0;
      pend_x       <= 1'b0;
      pend_y       <= 1'b0;
    end else begin
      ball_lost    <= 1'b0;
      display_ball <= game_run && (state == IDLE || state == MOVE);
      pend_x       <= (move_tick ? 1'b0 : pend_x) | (brick_hit & brick_axis);
      pend_y       <= (move_tick ? 1'b0 : pend_y) | (brick_hit & ~brick_axis);
      case (state)
        IDLE: begin
          if (game_run) begin
            if (frame_tick) begin
              ball_x <= park_x;
              ball_y <= POS_W'(PARK_Y);
            end
            if (launch) begin
              state   <= MOVE;
              dir_x   <= DIR_RIGHT;
              dir_y   <= ~DIR_DOWN;
              speed   <= 4'(VEL_INIT);
              hit_cnt <= '0;
            end
          end
        end
        MOVE: begin
          if (move_tick) begin
            if (!paddle_hit && floor_hit) begin
              state      <= LOST;
              ball_lost  <= 1'b1;
              lives_left <= lives_left - 2'd1;
            end else begin
              ball_x <= nx;
              dir_x  <= bx ? ~eff_dx : eff_dx;
              if (paddle_hit) begin
                ball_y <= POS_W'(PARK_Y);
                dir_y  <= ~DIR_DOWN;
                if (hit_cnt == 4'(HITS_PER_LEVEL - 1)) begin
                  hit_cnt <= '0;
                  if (speed < 4'(VEL_MAX)) speed <= speed + 4'd1;
                end else begin
                  hit_cnt <= hit_cnt + 4'd1;
                end
              end else begin
                ball_y <= ny;
                dir_y  <= by ? ~eff_dy : eff_dy;
              end
            end
          end
        end
        LOST: begin
          state     <= (lives_left != 2'd0) ? IDLE : OVER;
          game_over <= (lives_left == 2'd0);
        end
        OVER:    game_over <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ball_engine.md
# ball_engine

Parametrised ball motion engine for the brick-breaker playfield. Advances one ball once per video frame and reflects it off the side and top walls, the paddle and bricks reported by the brick-collision logic. It tracks paddle hits to raise ball speed, owns serve/launch and lives bookkeeping, and feeds the pixel renderer and the game controller.

## Interface
- SCREEN_W, 640: playfield width in pixels.
- SCREEN_H, 480: playfield height in pixels.
- BALL_SIZE, 16: ball edge length (square).
- PADDLE_W, 80: paddle width.
- PADDLE_Y, 448: paddle top row.
- POS_W, 10: position width; must hold SCREEN_W and SCREEN_H.
- VEL_INIT, 4: speed per axis at serve, in pixels/frame.
- VEL_MAX, 8: speed ceiling.
- HITS_PER_LEVEL, 4: paddle hits per +1 speed step.
- LIVES, 3: balls per game.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per frame.
- game_run  in  1  gate for all motion and launch.
- launch  in  1  serve request (level-sampled).
- paddle_x  in  POS_W  paddle left edge.
- brick_hit  in  1  one-cycle collision pulse from brick logic.
- brick_axis  in  1  0 = flip Y, 1 = flip X.
- ball_x, ball_y  out  POS_W each  ball top-left.
- dir_x  out  1  1 = right.
- dir_y  out  1  1 = down.
- speed  out  4  current velocity.
- lives_left  out  2  remaining balls.
- ball_lost  out  1  one-cycle pulse when a ball is missed.
- game_over  out  1  level; no lives left.
- display_ball  out  1  registered render enable.

## Operation
- FSM states: IDLE (ball parked on paddle), MOVE, LOST, OVER.
- IDLE, per frame_tick: ball_x = clamp(paddle_x + PADDLE_W/2 − BALL_SIZE/2, 0, SCREEN_W−BALL_SIZE); ball_y = PADDLE_Y−BALL_SIZE.
- IDLE to MOVE: launch & game_run. On entry dir_x=1, dir_y=0, speed=VEL_INIT, hit count=0.
- Brick hits: each brick_hit sets a pending flag for its axis; repeated hits on one axis OR together. Each set flag toggles its direction at the next MOVE frame_tick, before the step; flags clear on that tick.
- MOVE step, per frame_tick when game_run:
  - X right: if x+v ≥ SCREEN_W−BALL_SIZE, x = SCREEN_W−BALL_SIZE and dir_x=0.
  - X left: if x < v, x = 0 and dir_x=1.
  - Y up: if y < v, y = 0 and dir_y=1.
  - Y down, paddle: paddle hit when y+BALL_SIZE ≤ PADDLE_Y ≤ y+v+BALL_SIZE, x+BALL_SIZE > paddle_x and x < paddle_x+PADDLE_W. Then y = PADDLE_Y−BALL_SIZE, dir_y=0, hit count+1.
  - Y down, floor: otherwise, if y+v ≥ SCREEN_H−BALL_SIZE, go to LOST.
  - Otherwise x±v and y±v.
- Wall and paddle reflections set direction absolutely, so they override a same-tick brick toggle.
- Speed: after every HITS_PER_LEVEL paddle hits, speed = min(speed+1, VEL_MAX).
- LOST entry: ball_lost pulses for one cycle, lives_left decrements, position freezes. Next state is IDLE if lives_left > 0, otherwise OVER.
- OVER: game_over=1. launch is ignored. Only rst leaves OVER.
- display_ball = game_run & state ∈ {IDLE, MOVE}, registered.
- Arithmetic is done at POS_W+1 bits to avoid wrap-around. Positions never leave [0, SCREEN_W−BALL_SIZE] × [0, SCREEN_H−BALL_SIZE].

## Timing
- Reset values: state IDLE, ball_x=(SCREEN_W−BALL_SIZE)/2, ball_y=PADDLE_Y−BALL_SIZE, dir_x=1, dir_y=0, speed=VEL_INIT, lives_left=LIVES, ball_lost=0, game_over=0, display_ball=0, pending flags cleared.
- Position and direction update in the cycle after frame_tick (registered, 1-cycle latency).
- ball_lost and the lives decrement occur in the cycle after the detecting tick. The LOST→IDLE/OVER transition occurs on the following clk.
- A brick_hit in the same cycle as frame_tick is pending for the next tick, not the current one.
- game_run=0 freezes all state; pending brick flags are retained.
- rst mid-MOVE: all outputs go to reset values immediately (asynchronous).

## Structure
- Shared package ball_pkg holds the state enum {IDLE, MOVE, LOST, OVER} and the DIR_RIGHT/DIR_DOWN constants.
- Sub-module ball_axis_step: one axis; computes position ± velocity with low/high clamp and returns next position plus a bounce flag. Instantiated for X, and for Y's top bound. Paddle and floor logic stay in ball_engine.

## Test plan
- Reset, paddle_x=280, tick → (312,432). Launch, tick → (316,428), dir_x=1, dir_y=0.
- x=620, right, v=4, tick → x=624, dir_x=0. y=2, up, tick → y=0, dir_y=1.
- y=430, down, x=320, paddle_x=300, tick → y=432, dir_y=0. After 4 such hits, speed=5. After 16 hits, speed=8, and it stays 8.
- brick_hit axis 0 while moving up at y=200 → next tick dir_y=1, y=204. brick_hit together with the right-wall hit → dir_x=0, not toggled back.
- Miss: paddle_x=0, x=500, y=462, down → ball_lost pulse, lives_left 3→2, IDLE. After the third miss, game_over=1 and launch is ignored.
- rst asserted mid-MOVE without a clock edge → outputs return to reset values at once.
